// File: rtl/set_assoc_cache_pkg.sv
// Shared types and width helpers for the set-associative write-through cache.
// FSM encodings live here so the top and any debug tooling agree on them.
package set_assoc_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_RESP   = 2'd2,
    ST_WRITE  = 2'd3
  } state_t;

  // Index width that never collapses to zero bits (a 1-entry space still gets one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tag_w(input int addr_w, input int sets_log2, input int off_log2);
    return addr_w - sets_log2 - off_log2;
  endfunction

endpackage

// File: rtl/set_assoc_cache_lru.sv
// Age-based true-LRU helper: touches the hit way and names the refill victim.
// Purely combinational; the top owns the per-set age registers.
module cache_lru_ages
  import set_assoc_cache_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int AGE_W = idx_w(WAYS)
) (
  input  logic [WAYS*AGE_W-1:0] i_ages,
  input  logic [WAYS-1:0]       i_valid,
  input  logic [AGE_W-1:0]      i_hit_way,
  output logic [WAYS*AGE_W-1:0] o_ages,
  output logic [AGE_W-1:0]      o_victim
);

  logic [AGE_W-1:0] w_hit_age;
  logic             w_found;

  always_comb begin
    o_ages    = '0;
    o_victim  = '0;
    w_found   = 1'b0;
    w_hit_age = i_ages[int'(i_hit_way)*AGE_W +: AGE_W];
    if (WAYS > 1) begin
      for (int w = 0; w < WAYS; w++) begin
        if (w == int'(i_hit_way))
          o_ages[w*AGE_W +: AGE_W] = '0;
        else if (i_ages[w*AGE_W +: AGE_W] < w_hit_age)
          o_ages[w*AGE_W +: AGE_W] = i_ages[w*AGE_W +: AGE_W] + AGE_W'(1);
        else
          o_ages[w*AGE_W +: AGE_W] = i_ages[w*AGE_W +: AGE_W];
        if (i_ages[w*AGE_W +: AGE_W] == AGE_W'(WAYS - 1))
          o_victim = AGE_W'(w);
      end
      // An empty way always beats the oldest one; lowest index wins.
      for (int w = 0; w < WAYS; w++) begin
        if (!w_found && !i_valid[w]) begin
          o_victim = AGE_W'(w);
          w_found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative, write-through, no-write-allocate data cache with
// multi-beat line refill, write-hit update, true-LRU replacement and flush.
module set_assoc_cache
  import set_assoc_cache_pkg::*;
#(
  parameter int ADDR_W    = 17,
  parameter int WORD_W    = 32,
  parameter int SETS_LOG2 = 6,
  parameter int WAYS      = 2,
  parameter int OFF_LOG2  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam int TAG_W  = tag_w(ADDR_W, SETS_LOG2, OFF_LOG2);
  localparam int AGE_W  = idx_w(WAYS);
  localparam int SETS   = 1 << SETS_LOG2;
  localparam int WPL    = 1 << OFF_LOG2;
  localparam int IDX_W  = SETS_LOG2 + OFF_LOG2;
  localparam int BEAT_W = idx_w(WPL);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(WPL - 1);

  state_t                r_state, w_next;
  logic [WAYS-1:0]       r_valid [SETS];
  logic [TAG_W-1:0]      r_tag   [SETS][WAYS];
  logic [WAYS*AGE_W-1:0] r_age   [SETS];
  logic [WORD_W-1:0]     r_mem   [WAYS][SETS*WPL];
  logic [ADDR_W-1:0]     r_addr;
  logic [WORD_W-1:0]     r_wdata, r_rdata;
  logic                  r_hit;
  logic [AGE_W-1:0]      r_way;
  logic [BEAT_W-1:0]     r_beat;

  logic [SETS_LOG2-1:0]  w_set, w_rset, w_lru_set;
  logic [TAG_W-1:0]      w_tag, w_rtag;
  logic [IDX_W-1:0]      w_idx, w_ridx;
  logic [BEAT_W-1:0]     w_roff;
  logic [WAYS-1:0]       w_hit_vec, w_age_seen;
  logic                  w_hit, w_accept, w_last, w_beat_in, w_touch;
  logic [AGE_W-1:0]      w_hit_way, w_lru_way, w_victim;
  logic [WAYS*AGE_W-1:0] w_ages_new;

  assign w_set  = req_addr[OFF_LOG2 +: SETS_LOG2];
  assign w_tag  = req_addr[ADDR_W-1 -: TAG_W];
  assign w_idx  = req_addr[IDX_W-1:0];
  assign w_rset = r_addr[OFF_LOG2 +: SETS_LOG2];
  assign w_rtag = r_addr[ADDR_W-1 -: TAG_W];
  assign w_roff = BEAT_W'(r_addr & OFF_MASK);
  assign w_ridx = (IDX_W'(w_rset) << OFF_LOG2) | IDX_W'(r_beat);

  always_comb begin
    w_hit_vec = '0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_hit_vec[w] = r_valid[w_set][w] && (r_tag[w_set][w] == w_tag);
      if (w_hit_vec[w]) w_hit_way = AGE_W'(w);
    end
  end
  assign w_hit = |w_hit_vec;

  assign w_accept  = (r_state == ST_IDLE) && req_valid && !flush;
  assign w_beat_in = (r_state == ST_REFILL) && mem_rvalid;
  assign w_last    = (r_beat == BEAT_W'(WPL - 1));
  assign w_touch   = (w_accept && w_hit) || (w_beat_in && w_last);

  // In IDLE the LRU looks at the incoming request's set; afterwards at the registered one.
  assign w_lru_set = (r_state == ST_IDLE) ? w_set : w_rset;
  assign w_lru_way = (r_state == ST_IDLE) ? w_hit_way : r_way;

  cache_lru_ages #(.WAYS(WAYS), .AGE_W(AGE_W)) u_lru (
    .i_ages    (r_age[w_lru_set]),
    .i_valid   (r_valid[w_lru_set]),
    .i_hit_way (w_lru_way),
    .o_ages    (w_ages_new),
    .o_victim  (w_victim)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = !flush;
        if (w_accept) w_next = req_we ? ST_WRITE : (w_hit ? ST_RESP : ST_REFILL);
      end
      ST_REFILL: begin
        mem_rd_req = 1'b1;
        mem_addr   = r_addr & ~OFF_MASK;
        if (w_beat_in && w_last) w_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        w_next     = ST_IDLE;
      end
      ST_WRITE: begin
        mem_wr_req = 1'b1;
        mem_addr   = r_addr;
        mem_wdata  = r_wdata;
        if (mem_ack) w_next = ST_RESP;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Control: valid/age/tag bookkeeping and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_age[s][w*AGE_W +: AGE_W] <= AGE_W'(w);
      end
      r_hit   <= 1'b0;
      r_way   <= '0;
      r_beat  <= '0;
      r_rdata <= '0;
    end else begin
      if ((r_state == ST_IDLE) && flush)
        for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
      if (w_touch) r_age[w_lru_set] <= w_ages_new;
      if (w_accept) begin
        r_hit  <= w_hit;
        r_beat <= '0;
        r_way  <= w_hit ? w_hit_way : w_victim;
        if (!req_we && w_hit) r_rdata <= r_mem[w_hit_way][w_idx];
      end
      if (w_beat_in) begin
        r_beat <= r_beat + BEAT_W'(1);
        if (r_beat == w_roff) r_rdata <= mem_rdata;
        // Line becomes visible only once every beat has landed.
        if (w_last) begin
          r_tag[w_rset][r_way]   <= w_rtag;
          r_valid[w_rset][r_way] <= 1'b1;
        end
      end
    end
  end

  // Datapath: request capture and word RAM writes.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      if (req_we && w_hit) r_mem[w_hit_way][w_idx] <= req_wdata;
    end
    if (w_beat_in) r_mem[r_way][w_ridx] <= mem_rdata;
  end

  assign resp_rdata = r_rdata;
  assign resp_hit   = r_hit;

  always_comb begin
    w_age_seen = '0;
    for (int w = 0; w < WAYS; w++) w_age_seen[r_age[w_lru_set][w*AGE_W +: AGE_W]] = 1'b1;
  end

  a_hit_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(w_hit_vec));
  a_ages_perm:  assert property (@(posedge clk) disable iff (rst) &w_age_seen);

endmodule

// File: tb/tb_set_assoc_cache.sv
// Bench for set_assoc_cache: a default 2-way instance and a 4-way/4-word instance
// share stimulus; sel4 picks which one is driven and observed.
module tb_set_assoc_cache;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, flush = 1'b0, req_valid = 1'b0, req_we = 1'b0, sel4 = 1'b0;
  logic        mem_ack = 1'b0, mem_rvalid = 1'b0;
  logic [16:0] req_addr = '0;
  logic [31:0] req_wdata = '0, mem_rdata = '0;

  logic        rr2, rv2, rh2, mrd2, mwr2, rr4, rv4, rh4, mrd4, mwr4;
  logic [31:0] rd2, mwd2, rd4, mwd4;
  logic [16:0] ma2, ma4;

  logic        req_ready, resp_valid, resp_hit, mem_rd_req, mem_wr_req;
  logic [31:0] resp_rdata, mem_wdata;
  logic [16:0] mem_addr;

  assign req_ready  = sel4 ? rr4  : rr2;
  assign resp_valid = sel4 ? rv4  : rv2;
  assign resp_hit   = sel4 ? rh4  : rh2;
  assign resp_rdata = sel4 ? rd4  : rd2;
  assign mem_rd_req = sel4 ? mrd4 : mrd2;
  assign mem_wr_req = sel4 ? mwr4 : mwr2;
  assign mem_addr   = sel4 ? ma4  : ma2;
  assign mem_wdata  = sel4 ? mwd4 : mwd2;

  set_assoc_cache u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid & ~sel4), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(rr2), .resp_valid(rv2), .resp_rdata(rd2), .resp_hit(rh2),
    .mem_rd_req(mrd2), .mem_wr_req(mwr2), .mem_addr(ma2), .mem_wdata(mwd2),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  set_assoc_cache #(.WAYS(4), .OFF_LOG2(2)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid & sel4), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(rr4), .resp_valid(rv4), .resp_rdata(rd4), .resp_hit(rh4),
    .mem_rd_req(mrd4), .mem_wr_req(mwr4), .mem_addr(ma4), .mem_wdata(mwd4),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        s4;
    logic        we;
    logic [16:0] addr;
    logic [31:0] wd;
    int          ack;
    logic        eh;
    logic [31:0] erd;
  } vec_t;

  typedef struct {
    logic        we;
    logic        hit;
    logic [31:0] rdata;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] bk[int];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Backing store: written words remembered, everything else is addr + 0x90.
  function automatic logic [31:0] mem_rd(input logic [16:0] a);
    if (bk.exists(int'(a))) return bk[int'(a)];
    return 32'(a) + 32'h90;
  endfunction

  task automatic access(input logic s4, input logic we, input logic [16:0] addr,
                        input logic [31:0] wd, input int ack, input logic eh,
                        input logic [31:0] erd, input string nm);
    int          cyc, beats, wrc, wpl;
    logic        rd_seen, done;
    logic [16:0] base;
    sb_t         e;
    wpl  = s4 ? 4 : 2;
    base = addr & ~17'(wpl - 1);
    @(negedge clk);
    sel4 = s4; req_we = we; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    #1;
    chk({nm, " ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    e.we = we; e.hit = eh; e.rdata = erd;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0; beats = 0; wrc = 0; rd_seen = 1'b0; done = 1'b0;
    while (!done && cyc < 60) begin
      cyc++;
      mem_rvalid = 1'b0;
      mem_ack    = 1'b0;
      if (resp_valid) begin
        done = 1'b1;
        if (sb.size() == 0) chk({nm, " sb empty"}, 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk({nm, " hit"}, 32'(resp_hit), 32'(e.hit));
          if (!e.we) chk({nm, " rdata"}, resp_rdata, e.rdata);
        end
      end else begin
        if (mem_rd_req) begin
          if (!rd_seen) chk({nm, " rd addr"}, 32'(mem_addr), 32'(base));
          rd_seen = 1'b1;
          if (beats < wpl) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_rd(base + 17'(beats));
            beats++;
          end
        end
        if (mem_wr_req) begin
          wrc++;
          if (wrc == 1) begin
            chk({nm, " wr addr"}, 32'(mem_addr), 32'(addr));
            chk({nm, " wr data"}, mem_wdata, wd);
          end
          if (wrc == ack) begin
            mem_ack = 1'b1;
            bk[int'(addr)] = wd;
          end
        end
        @(negedge clk);
      end
    end
    if (!done) chk({nm, " timeout"}, 32'd0, 32'd1);
    if (!we) chk({nm, " refill seen"}, 32'(rd_seen), 32'(!eh));
    if (!we && eh) chk({nm, " latency"}, 32'(cyc), 32'd1);
    if (we) begin
      chk({nm, " wr cycles"}, 32'(wrc), 32'(ack));
      chk({nm, " latency"}, 32'(cyc), 32'(ack + 1));
    end
    @(negedge clk);
    chk({nm, " pulse"}, 32'(resp_valid), 32'd0);
  endtask

  vec_t tA[13];
  vec_t tB[8];

  initial begin
    int k;
    tA = '{
      '{1'b0, 1'b0, 17'h010, 32'h0,    0, 1'b0, 32'hA0},
      '{1'b0, 1'b0, 17'h011, 32'h0,    0, 1'b1, 32'hA1},
      '{1'b0, 1'b0, 17'h080, 32'h0,    0, 1'b0, 32'h110},
      '{1'b0, 1'b0, 17'h100, 32'h0,    0, 1'b0, 32'h190},
      '{1'b0, 1'b0, 17'h080, 32'h0,    0, 1'b1, 32'h110},
      '{1'b0, 1'b0, 17'h180, 32'h0,    0, 1'b0, 32'h210},
      '{1'b0, 1'b0, 17'h081, 32'h0,    0, 1'b1, 32'h111},
      '{1'b0, 1'b0, 17'h180, 32'h0,    0, 1'b1, 32'h210},
      '{1'b0, 1'b0, 17'h100, 32'h0,    0, 1'b0, 32'h190},
      '{1'b0, 1'b1, 17'h010, 32'hDEAD, 3, 1'b1, 32'h0},
      '{1'b0, 1'b0, 17'h010, 32'h0,    0, 1'b1, 32'hDEAD},
      '{1'b0, 1'b1, 17'h200, 32'hBEEF, 1, 1'b0, 32'h0},
      '{1'b0, 1'b0, 17'h200, 32'h0,    0, 1'b0, 32'hBEEF}
    };
    tB = '{
      '{1'b1, 1'b0, 17'h004, 32'h0, 0, 1'b0, 32'h94},
      '{1'b1, 1'b0, 17'h104, 32'h0, 0, 1'b0, 32'h194},
      '{1'b1, 1'b0, 17'h204, 32'h0, 0, 1'b0, 32'h294},
      '{1'b1, 1'b0, 17'h304, 32'h0, 0, 1'b0, 32'h394},
      '{1'b1, 1'b0, 17'h404, 32'h0, 0, 1'b0, 32'h494},
      '{1'b1, 1'b0, 17'h004, 32'h0, 0, 1'b0, 32'h94},
      '{1'b1, 1'b0, 17'h404, 32'h0, 0, 1'b1, 32'h494},
      '{1'b1, 1'b0, 17'h207, 32'h0, 0, 1'b1, 32'h297}
    };

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset ready",      32'(req_ready),  32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_hit",   32'(resp_hit),   32'd0);
    chk("reset rdata",      resp_rdata,      32'd0);
    chk("reset mem_rd_req", 32'(mem_rd_req), 32'd0);
    chk("reset mem_wr_req", 32'(mem_wr_req), 32'd0);
    chk("reset ready4",     32'(rr4),        32'd1);

    for (int i = 0; i < 13; i++)
      access(tA[i].s4, tA[i].we, tA[i].addr, tA[i].wd, tA[i].ack, tA[i].eh, tA[i].erd,
             $sformatf("A%0d", i));

    // Flush with a simultaneous request: request refused, all lines dropped.
    @(negedge clk);
    sel4 = 1'b0; flush = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 17'h010;
    #1;
    chk("flush ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    #1;
    chk("flush not accepted", 32'(mem_rd_req | resp_valid), 32'd0);
    access(1'b0, 1'b0, 17'h011, 32'h0, 0, 1'b0, 32'hA1,  "flush 011");
    access(1'b0, 1'b0, 17'h100, 32'h0, 0, 1'b0, 32'h190, "flush 100");
    access(1'b0, 1'b0, 17'h201, 32'h0, 0, 1'b0, 32'h291, "flush 201");

    // Reset after the first refill beat aborts the refill.
    @(negedge clk);
    sel4 = 1'b0; req_we = 1'b0; req_addr = 17'h040; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!mem_rd_req && k < 5) begin
      @(negedge clk);
      k++;
    end
    chk("abort rd_req up", 32'(mem_rd_req), 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hD0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort rd_req drop", 32'(mem_rd_req), 32'd0);
    chk("abort ready",       32'(req_ready),  32'd1);
    rst = 1'b0;
    access(1'b0, 1'b0, 17'h040, 32'h0, 0, 1'b0, 32'hD0, "abort reread");

    for (int i = 0; i < 8; i++)
      access(tB[i].s4, tB[i].we, tB[i].addr, tB[i].wd, tB[i].ack, tB[i].eh, tB[i].erd,
             $sformatf("B%0d", i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
